// File: rtl/vc_stream_rr_arbiter.sv
// rtl/vc_stream_rr_arbiter.sv - round-robin merge of p_nreqs val/rdy streams into one buffered stream
//
// Purpose:
//   Merges p_nreqs val/rdy message streams onto a single val/rdy output
//   through a one-entry registered buffer. The grant rotates round-robin,
//   starting at the stream after the last one served. The buffer may drain
//   and refill in the same cycle. in_rdy depends on out_rdy only through
//   can_accept. There is no path from out_rdy through the buffer.
//
// Ports:
//   clk      in   1                 clock, rising edge
//   reset    in   1                 asynchronous, active-high reset
//   in_val   in   p_nreqs           per-stream valid
//   in_rdy   out  p_nreqs           per-stream ready, at most one bit set
//   in_msg   in   p_nreqs*p_msg_sz  stream i in [i*p_msg_sz +: p_msg_sz]
//   out_val  out  1                 buffered message valid
//   out_rdy  in   1                 downstream ready
//   out_msg  out  p_msg_sz          buffered message
//                                   ({index, message} with the tag build)
//
// Build option:
//   VC_STREAM_RR_ARBITER_TAG_EN - when defined, out_msg is widened by
//   p_idx_sz bits. The extra bits carry the index of the source stream,
//   which is registered alongside the message.

module vc_stream_rr_arbiter #(
  parameter int p_nreqs  = 4,
  parameter int p_msg_sz = 8,
  parameter int p_idx_sz = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [p_nreqs-1:0]           in_val,
  output logic [p_nreqs-1:0]           in_rdy,
  input  logic [p_nreqs*p_msg_sz-1:0]  in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
`ifdef VC_STREAM_RR_ARBITER_TAG_EN
  output logic [p_idx_sz+p_msg_sz-1:0] out_msg
`else
  output logic [p_msg_sz-1:0]          out_msg
`endif
);

  logic [p_idx_sz-1:0] r_prio_ptr;
  logic                r_out_val;
  logic [p_msg_sz-1:0] r_msg;
`ifdef VC_STREAM_RR_ARBITER_TAG_EN
  logic [p_idx_sz-1:0] r_tag;
`endif

  logic                w_can_accept;
  logic                w_found;
  logic [p_idx_sz-1:0] w_grant_idx;
  logic [p_msg_sz-1:0] w_sel_msg;
  logic [p_nreqs-1:0]  w_grant;
  logic                w_in_xfer;
  logic [p_idx_sz-1:0] w_next_ptr;

  // Pipelined-buffer rule: a buffered message leaving this cycle frees the
  // slot for a new one at the same edge.
  assign w_can_accept = !r_out_val || out_rdy;

  // Priority scan in two passes. The first pass covers streams at or above
  // the pointer. The second pass covers the wrapped-around streams below
  // it. The message mux is taken from the same winner, so an idle stream's
  // in_msg never reaches the buffer.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sel_msg   = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      if (!w_found && in_val[i] && (i >= int'(r_prio_ptr))) begin
        w_found     = 1'b1;
        w_grant_idx = p_idx_sz'(i);
        w_sel_msg   = in_msg[i*p_msg_sz +: p_msg_sz];
      end
    end
    for (int i = 0; i < p_nreqs; i++) begin
      if (!w_found && in_val[i] && (i < int'(r_prio_ptr))) begin
        w_found     = 1'b1;
        w_grant_idx = p_idx_sz'(i);
        w_sel_msg   = in_msg[i*p_msg_sz +: p_msg_sz];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      w_grant[i] = w_found && (w_grant_idx == p_idx_sz'(i));
    end
  end

  // in_rdy is held low during reset. It would otherwise advertise space,
  // because the cleared buffer makes can_accept true.
  assign in_rdy    = (reset || !w_can_accept) ? '0 : w_grant;
  assign w_in_xfer = w_can_accept && w_found && !reset;

  assign w_next_ptr = (int'(w_grant_idx) == p_nreqs - 1) ? '0
                                                         : w_grant_idx + p_idx_sz'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_val  <= 1'b0;
      r_msg      <= '0;
      r_prio_ptr <= '0;
`ifdef VC_STREAM_RR_ARBITER_TAG_EN
      r_tag      <= '0;
`endif
    end else if (w_in_xfer) begin
      r_out_val  <= 1'b1;
      r_msg      <= w_sel_msg;
      r_prio_ptr <= w_next_ptr;
`ifdef VC_STREAM_RR_ARBITER_TAG_EN
      r_tag      <= w_grant_idx;
`endif
    end else if (r_out_val && out_rdy) begin
      // Drained with nothing behind it. The message bits are left in place.
      r_out_val  <= 1'b0;
    end
  end

  assign out_val = r_out_val;
`ifdef VC_STREAM_RR_ARBITER_TAG_EN
  assign out_msg = {r_tag, r_msg};
`else
  assign out_msg = r_msg;
`endif

endmodule

// File: tb/tb_vc_stream_rr_arbiter.sv
// tb/tb_vc_stream_rr_arbiter.sv - directed scoreboard bench for vc_stream_rr_arbiter

module tb_vc_stream_rr_arbiter;

  localparam int NR = 4;
  localparam int MW = 8;
  localparam int IW = 2;
`ifdef VC_STREAM_RR_ARBITER_TAG_EN
  localparam int OW = IW + MW;
`else
  localparam int OW = MW;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     in_val;
  logic [NR-1:0]     in_rdy;
  logic [NR*MW-1:0]  in_msg;
  logic              out_val;
  logic              out_rdy;
  logic [OW-1:0]     out_msg;

  vc_stream_rr_arbiter #(
    .p_nreqs (NR),
    .p_msg_sz(MW),
    .p_idx_sz(IW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .in_msg (in_msg),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] src_mem [NR][32];
  int            head [NR];
  int            tail [NR];
  logic [OW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_err = 0;
  logic [IW-1:0] m_ptr;
  logic          m_oval;
  bit            rnd_rdy;

  function automatic logic [OW-1:0] mk(input int idx, input logic [MW-1:0] m);
    logic [IW+MW-1:0] full;
    full = {IW'(idx), m};
    return full[OW-1:0];
  endfunction

  function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input logic [IW-1:0] p);
    logic [NR-1:0] g;
    bit            found;
    g = '0;
    found = 1'b0;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (int'(p) + k) % NR;
      if (!found && v[j]) begin
        g[j] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_src(input int i, input logic [MW-1:0] m);
    src_mem[i][tail[i]] = m;
    tail[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      in_val[i] = (head[i] < tail[i]);
      in_msg[i*MW +: MW] = in_val[i] ? src_mem[i][head[i]] : 'x;
    end
  endtask

  // One clock cycle. Checks run at the falling edge, where the inputs are
  // stable. The handshakes seen there commit at the next rising edge.
  task automatic step();
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] acc;
    logic [NR-1:0] macc;
    logic [OW-1:0] e;
    @(negedge clk);
    exp_rdy = reset ? '0 : ((!m_oval || out_rdy) ? model_grant(in_val, m_ptr) : '0);
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    chk("out_val", 32'(out_val), 32'(m_oval));
    if (out_val === 1'b1 && out_rdy === 1'b1) begin
      chk("out_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_msg", 32'(out_msg), 32'(e));
      end
    end else if (out_val === 1'b1 && exp_q.size() > 0) begin
      chk("out_hold", 32'(out_msg), 32'(exp_q[0]));
    end
    acc  = in_val & in_rdy;
    macc = exp_rdy & in_val;
    if (reset) begin
      m_oval = 1'b0;
      m_ptr  = '0;
    end else if (macc != '0) begin
      m_oval = 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (macc[i]) m_ptr = IW'((i + 1) % NR);
      end
    end else if (m_oval && out_rdy) begin
      m_oval = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) head[i]++;
    end
    if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || out_val === 1'b1) && n < bound) begin
      step();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    out_rdy = 1'b1;
    rnd_rdy = 1'b0;
    m_ptr   = '0;
    m_oval  = 1'b0;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    // Reset held with every stream valid; first grant afterwards is stream 0.
    for (int i = 0; i < NR; i++) push_src(i, 8'h50 + 8'(i));
    drive();
    repeat (3) step();
    chk("rst_out_msg", 32'(out_msg), 32'd0);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) exp_q.push_back(mk(i, 8'h50 + 8'(i)));
    drain(40);

    // Single stream 2 sending aa, bb, cc.
    push_src(2, 8'haa);
    push_src(2, 8'hbb);
    push_src(2, 8'hcc);
    exp_q.push_back(mk(2, 8'haa));
    exp_q.push_back(mk(2, 8'hbb));
    exp_q.push_back(mk(2, 8'hcc));
    drive();
    drain(40);

    // All four streams valid. The pointer now sits at 3, so the order is
    // 3,0,1,2 repeated, which covers the 3->0 wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NR; i++) push_src(i, 8'h10 + 8'(i));
      for (int k = 0; k < NR; k++) exp_q.push_back(mk((3 + k) % NR, 8'h10 + 8'((3 + k) % NR)));
    end
    drive();
    drain(60);

    // Backpressure: one accept fills the buffer, then five stalled cycles.
    out_rdy = 1'b0;
    push_src(0, 8'h21);
    push_src(0, 8'h22);
    push_src(1, 8'h31);
    exp_q.push_back(mk(0, 8'h21));
    exp_q.push_back(mk(1, 8'h31));
    exp_q.push_back(mk(0, 8'h22));
    drive();
    repeat (6) step();
    chk("bp_in_rdy", 32'(in_rdy), 32'd0);
    chk("bp_out_msg", 32'(out_msg), 32'(mk(0, 8'h21)));
    out_rdy = 1'b1;
    drain(20);

    // Skip idle streams: only 1 and 3 valid from ptr=1, then stream 3 runs dry.
    for (int j = 0; j < 4; j++) push_src(1, 8'h41 + 8'(j));
    push_src(3, 8'h61);
    push_src(3, 8'h62);
    exp_q.push_back(mk(1, 8'h41));
    exp_q.push_back(mk(3, 8'h61));
    exp_q.push_back(mk(1, 8'h42));
    exp_q.push_back(mk(3, 8'h62));
    exp_q.push_back(mk(1, 8'h43));
    exp_q.push_back(mk(1, 8'h44));
    drive();
    drain(40);

    // Random downstream stalls with all streams loaded; from ptr=2.
    rnd_rdy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) push_src(i, 8'(i * 16 + r));
      for (int k = 0; k < NR; k++) exp_q.push_back(mk((2 + k) % NR, 8'(((2 + k) % NR) * 16 + r)));
    end
    drive();
    drain(400);
    rnd_rdy = 1'b0;
    out_rdy = 1'b1;
    repeat (2) step();
    chk("idle_in_rdy", 32'(in_rdy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
